// File: rtl/branch_cmp_pipe.sv
// Pipelined branch-condition unit: 1- or 2-stage latency, valid/ready handshake and flush.
// Define BRANCH_STATS_EN to add saturating taken / not-taken handshake counters.
module branch_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int PIPE  = 1
`ifdef BRANCH_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
`ifdef BRANCH_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] ntaken_cnt,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [3:0]        cmp_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic              out_illeg,
  output logic [TAG_W-1:0]  out_tag
);

  // Flag vector layout: {eq, a_zero, b_zero, a_neg, lt_s, lt_u}
  localparam int F_EQ = 5, F_AZ = 4, F_BZ = 3, F_AN = 2, F_LTS = 1, F_LTU = 0;

  function automatic logic [1:0] decode(input logic [3:0] op, input logic [5:0] f);
    logic tk;
    logic il;
    tk = 1'b0;
    il = 1'b0;
    case (op)
      4'b0000: tk = f[F_EQ];
      4'b0001: tk = !f[F_EQ];
      4'b0010: tk = f[F_LTS];
      4'b0011: tk = f[F_LTU];
      4'b0100: tk = !f[F_AN];
      4'b0101: tk = !f[F_AN] && !f[F_AZ];
      4'b0110: tk = f[F_AN] || f[F_AZ];
      4'b0111: tk = f[F_AN];
      4'b1000: tk = f[F_BZ];
      4'b1001: tk = !f[F_LTS];
      4'b1010: tk = !f[F_LTU];
      default: il = 1'b1;
    endcase
    return {tk, il};
  endfunction

  logic             en;
  logic [5:0]       flags;
  logic             stg_valid;
  logic             stg_taken;
  logic             stg_illeg;
  logic [TAG_W-1:0] stg_tag;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !flush;
  assign flags    = {a == b, a == '0, b == '0, a[WIDTH-1], $signed(a) < $signed(b), a < b};

  // stg_* feeds the output register; with PIPE=2 a flag stage sits in front of the decode.
  generate
    if (PIPE == 2) begin : g_pipe2
      logic             s1_valid;
      logic [3:0]       s1_op;
      logic [TAG_W-1:0] s1_tag;
      logic [5:0]       s1_flags;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_op    <= '0;
          s1_tag   <= '0;
          s1_flags <= '0;
        end else if (flush) begin
          s1_valid <= 1'b0;
        end else if (en) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_op    <= cmp_op;
            s1_tag   <= in_tag;
            s1_flags <= flags;
          end
        end
      end

      assign stg_valid              = s1_valid;
      assign {stg_taken, stg_illeg} = decode(s1_op, s1_flags);
      assign stg_tag                = s1_tag;
    end else begin : g_pipe1
      assign stg_valid              = in_valid;
      assign {stg_taken, stg_illeg} = decode(cmp_op, flags);
      assign stg_tag                = in_tag;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_taken <= 1'b0;
      out_illeg <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= stg_valid;
      if (stg_valid) begin
        out_taken <= stg_taken;
        out_illeg <= stg_illeg;
        out_tag   <= stg_tag;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic count_hs;
  assign count_hs = out_valid && out_ready && !out_illeg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (stat_clr) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (count_hs) begin
      if (out_taken) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      end else begin
        if (ntaken_cnt != '1) ntaken_cnt <= ntaken_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Scoreboard bench driving a PIPE=1 and a PIPE=2 instance with shared directed stimulus.
// Stats checks are compiled only when BRANCH_STATS_EN is defined.
module tb_branch_cmp_pipe;

  typedef struct {
    logic       taken;
    logic       illeg;
    logic [3:0] tag;
    int         exp_cyc;
    logic       chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  cmp_op = '0;
  logic [3:0]  in_tag = '0;
  logic        exp_taken = 1'b0;
  logic        exp_illeg = 1'b0;
  logic        lat_chk = 1'b1;

  logic        ir  [2];
  logic        ov  [2];
  logic        otk [2];
  logic        oil [2];
  logic [3:0]  otg [2];

  exp_t        q [2][$];
  logic        hold [2];
  logic        htk  [2];
  logic        hil  [2];
  logic [3:0]  htg  [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

`ifdef BRANCH_STATS_EN
  logic       stat_clr = 1'b0;
  logic [3:0] tcnt [2];
  logic [3:0] ncnt [2];
`endif

  branch_cmp_pipe #(
    .WIDTH(32), .TAG_W(4), .PIPE(1)
`ifdef BRANCH_STATS_EN
    , .STAT_W(4)
`endif
  ) u_p1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef BRANCH_STATS_EN
    .stat_clr(stat_clr), .taken_cnt(tcnt[0]), .ntaken_cnt(ncnt[0]),
`endif
    .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .cmp_op(cmp_op), .in_tag(in_tag),
    .out_valid(ov[0]), .out_ready(out_ready), .out_taken(otk[0]), .out_illeg(oil[0]),
    .out_tag(otg[0])
  );

  branch_cmp_pipe #(
    .WIDTH(32), .TAG_W(4), .PIPE(2)
`ifdef BRANCH_STATS_EN
    , .STAT_W(4)
`endif
  ) u_p2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef BRANCH_STATS_EN
    .stat_clr(stat_clr), .taken_cnt(tcnt[1]), .ntaken_cnt(ncnt[1]),
`endif
    .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .cmp_op(cmp_op), .in_tag(in_tag),
    .out_valid(ov[1]), .out_ready(out_ready), .out_taken(otk[1]), .out_illeg(oil[1]),
    .out_tag(otg[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s pipe%0d: got %0h, required %0h", name, k + 1, act, exp);
    end
  endtask

  // Expected result is queued on accept; latency of instance k is k+1 cycles.
  always @(negedge clk) begin
    if (rst_n && in_valid) begin
      for (int k = 0; k < 2; k++)
        if (ir[k]) q[k].push_back('{exp_taken, exp_illeg, in_tag, cyc + k + 1, lat_chk});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        q[k].delete();
        hold[k] = 1'b0;
      end else begin
        if (hold[k]) begin
          check("hold_valid", k, 32'(ov[k]), 32'd1);
          check("hold_taken", k, 32'(otk[k]), 32'(htk[k]));
          check("hold_illeg", k, 32'(oil[k]), 32'(hil[k]));
          check("hold_tag", k, 32'(otg[k]), 32'(htg[k]));
        end
        if (ov[k] && out_ready) begin
          if (q[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result pipe%0d: got tag %0h, required no result", k + 1, otg[k]);
          end else begin
            e = q[k].pop_front();
            $display("pipe%0d result tag %0h taken %0b illeg %0b at cycle %0d", k + 1, otg[k],
                     otk[k], oil[k], cyc);
            check("taken", k, 32'(otk[k]), 32'(e.taken));
            check("illeg", k, 32'(oil[k]), 32'(e.illeg));
            check("tag", k, 32'(otg[k]), 32'(e.tag));
            if (e.chk_lat) check("latency_cycle", k, cyc, e.exp_cyc);
          end
        end
        if (flush) q[k].delete();
        hold[k] = ov[k] && !out_ready && !flush;
        htk[k]  = otk[k];
        hil[k]  = oil[k];
        htg[k]  = otg[k];
      end
    end
  end

  task automatic set_req(input logic [31:0] ta, input logic [31:0] tb2, input logic [3:0] op,
                         input logic [3:0] tag, input logic et, input logic ei);
    a = ta; b = tb2; cmp_op = op; in_tag = tag; exp_taken = et; exp_illeg = ei;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb2, input logic [3:0] op,
                      input logic [3:0] tag, input logic et, input logic ei);
    set_req(ta, tb2, op, tag, et, ei);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", k, 32'(ov[k]), 32'd0);
      check("rst_taken", k, 32'(otk[k]), 32'd0);
      check("rst_tag", k, 32'(otg[k]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("rst_in_ready", k, 32'(ir[k]), 32'd1);
    @(posedge clk);
    #1;

    // Equality, signed/unsigned relational, sign tests, illegal codes
    send(32'd5, 32'd5, 4'b0000, 4'h1, 1'b1, 1'b0);
    send(32'd5, 32'd5, 4'b0001, 4'h2, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 4'b0010, 4'h3, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 4'b0011, 4'h4, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 4'b1001, 4'h5, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 4'b1010, 4'h6, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 4'b0111, 4'h7, 1'b1, 1'b0);
    send(32'd0, 32'd1, 4'b0101, 4'h8, 1'b0, 1'b0);
    send(32'd7, 32'd0, 4'b1111, 4'h9, 1'b0, 1'b1);
    send(32'd7, 32'd0, 4'b1000, 4'hA, 1'b1, 1'b0);
    send(32'd0, 32'd3, 4'b0100, 4'hB, 1'b1, 1'b0);
    send(32'h8000_0000, 32'd3, 4'b0100, 4'hC, 1'b0, 1'b0);
    send(32'd0, 32'd3, 4'b0110, 4'hD, 1'b1, 1'b0);
    send(32'd3, 32'd3, 4'b0110, 4'hE, 1'b0, 1'b0);
    send(32'd7, 32'd9, 4'b0101, 4'hF, 1'b1, 1'b0);
    send(32'd7, 32'd9, 4'b1110, 4'h0, 1'b0, 1'b1);
    send(32'd2, 32'd9, 4'b1000, 4'h1, 1'b0, 1'b0);
    idle(4);

    // Four back-to-back requests, tags 1..4
    send(32'd1, 32'd2, 4'b0011, 4'h1, 1'b1, 1'b0);
    send(32'd2, 32'd2, 4'b0000, 4'h2, 1'b1, 1'b0);
    send(32'd3, 32'd2, 4'b0011, 4'h3, 1'b0, 1'b0);
    send(32'd4, 32'd2, 4'b1010, 4'h4, 1'b1, 1'b0);
    idle(4);

    // Back-pressure: three requests then out_ready low while tag 8 waits
    lat_chk = 1'b0;
    send(32'd1, 32'd1, 4'b0000, 4'h5, 1'b1, 1'b0);
    send(32'd1, 32'd2, 4'b0000, 4'h6, 1'b0, 1'b0);
    send(32'hFFFF_FFFE, 32'd2, 4'b0010, 4'h7, 1'b1, 1'b0);
    out_ready = 1'b0;
    set_req(32'd0, 32'd0, 4'b1000, 4'h8, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) check("stall_in_ready", k, 32'(ir[k]), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    idle(4);
    lat_chk = 1'b1;

    // Flush with requests in flight plus a new request in the flush cycle
    out_ready = 1'b0;
    send(32'd4, 32'd4, 4'b0000, 4'h9, 1'b1, 1'b0);
    send(32'd4, 32'd5, 4'b0000, 4'hA, 1'b0, 1'b0);
    set_req(32'd6, 32'd6, 4'b0000, 4'hB, 1'b1, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("post_flush_valid", k, 32'(ov[k]), 32'd0);
    @(posedge clk);
    #1;
    send(32'd9, 32'd8, 4'b0001, 4'hC, 1'b1, 1'b0);
    idle(4);

    // Reset in the middle of a burst
    send(32'd5, 32'd5, 4'b0000, 4'hD, 1'b1, 1'b0);
    send(32'd5, 32'd5, 4'b0000, 4'hE, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("midrst_valid", k, 32'(ov[k]), 32'd0);
      check("midrst_taken", k, 32'(otk[k]), 32'd0);
      check("midrst_illeg", k, 32'(oil[k]), 32'd0);
      check("midrst_tag", k, 32'(otg[k]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("midrst_in_ready", k, 32'(ir[k]), 32'd1);
    @(posedge clk);
    #1;
    send(32'd1, 32'd1, 4'b1011, 4'hF, 1'b0, 1'b1);
    idle(4);

`ifdef BRANCH_STATS_EN
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    send(32'd1, 32'd1, 4'b0000, 4'h1, 1'b1, 1'b0);
    send(32'd1, 32'd2, 4'b0000, 4'h2, 1'b0, 1'b0);
    send(32'd1, 32'd2, 4'b0011, 4'h3, 1'b1, 1'b0);
    send(32'd1, 32'd2, 4'b1111, 4'h4, 1'b0, 1'b1);
    send(32'd3, 32'd2, 4'b0011, 4'h5, 1'b0, 1'b0);
    send(32'd0, 32'd2, 4'b0100, 4'h6, 1'b1, 1'b0);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      check("stat_taken", k, 32'(tcnt[k]), 32'd3);
      check("stat_ntaken", k, 32'(ncnt[k]), 32'd2);
    end
    for (int i = 0; i < 16; i++) send(32'd1, 32'd1, 4'b0000, 4'h7, 1'b1, 1'b0);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      check("stat_saturate", k, 32'(tcnt[k]), 32'd15);
      check("stat_ntaken_kept", k, 32'(ncnt[k]), 32'd2);
    end
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("stat_clr_taken", k, 32'(tcnt[k]), 32'd0);
      check("stat_clr_ntaken", k, 32'(ncnt[k]), 32'd0);
    end
    send(32'd1, 32'd1, 4'b0000, 4'h8, 1'b1, 1'b0);
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("stat_rst", k, 32'(tcnt[k]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
`endif

    for (int i = 0; i < 20 && (q[0].size() != 0 || q[1].size() != 0); i++) @(posedge clk);
    check("drain_pending", 0, 32'(q[0].size() + q[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
